// File: rtl/organ_pkg.sv
// organ_pkg
// Shared types and constants for the organ sound path.
//   state_e       : auto-play sequencer states
//   ROM field map : song ROM word layout (notes, octave, duration, last flag)
//   max_int       : constant helper for width calculations
package organ_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_PAUSE,
    ST_DONE
  } state_e;

  localparam int ROM_W    = 18;
  localparam int NOTE_LSB = 0;
  localparam int NOTE_W   = 8;
  localparam int OCT_LSB  = 8;
  localparam int OCT_W    = 2;
  localparam int DUR_LSB  = 10;
  localparam int DUR_W    = 7;
  localparam int LAST_BIT = 17;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/play_scheduler_tick_prescaler.sv
// tick_prescaler
// Divides the system clock down to a 1 ms tick.
//   i_clk     : system clock
//   i_rst     : asynchronous active-high reset
//   i_clr     : restart the millisecond phase from zero
//   i_en      : count this cycle (phase is held while low)
//   o_ms_tick : one-cycle pulse on the last enabled cycle of each ms
module tick_prescaler #(
  parameter int TICK_CYC = 100_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_ms_tick
);

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [PW-1:0] r_cnt;
  logic          w_last;

  assign w_last    = (r_cnt == PW'(TICK_CYC - 1));
  assign o_ms_tick = i_en && w_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/play_scheduler.sv
// play_scheduler
// Shares the note/octave path to the tone generator between live keys and
// song auto-play. Live keys pass through when idle and pre-empt a running
// song, which pauses and later resumes with its remaining time intact.
//   sys_clk, rst_n       : clock, asynchronous active-high reset
//   live_note/live_shift : live key bitmap and octave
//   auto_req/auto_stop   : one-cycle start / abort pulses
//   rom_addr/rom_data    : song ROM port, one-cycle read latency
//   notes/shift          : registered outputs to the tone generator
//   busy/song_done       : song in progress / normal completion pulse
//
// state    | meaning
// IDLE     | live keys pass through, waiting for auto_req
// FETCH    | ROM read in flight
// LOAD     | latch ROM entry, start note timer (dur 0 ends song)
// PLAY     | sounding latched entry, ms down-counter running
// GAP      | silent gap after a note, then next entry or end
// PAUSE    | live keys override, timers frozen, return state saved
// DONE     | one-cycle completion pulse
module play_scheduler
  import organ_pkg::*;
#(
  parameter int TICK_CYC = 100_000,
  parameter int DUR_UNIT = 10,
  parameter int GAP_MS   = 20,
  parameter int ADDR_W   = 6
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [7:0]        live_note,
  input  logic [1:0]        live_shift,
  input  logic              auto_req,
  input  logic              auto_stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic [7:0]        notes,
  output logic [1:0]        shift,
  output logic              busy,
  output logic              song_done
);

  localparam int CNT_W = max_int($clog2(127 * DUR_UNIT + 1), $clog2(GAP_MS + 1));

  state_e            r_state, w_state_nxt;
  state_e            r_ret, w_ret_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_notes, w_notes_nxt;
  logic [1:0]        r_shift, w_shift_nxt;
  logic [7:0]        r_ent_notes;
  logic [1:0]        r_ent_oct;
  logic              r_ent_last;

  logic [DUR_W-1:0]  w_dur;
  logic [CNT_W-1:0]  w_dur_ms;
  logic              w_live, w_cnt_tc, w_ms_tick, w_pre_en, w_pre_clr;

  assign w_dur    = rom_data[DUR_LSB +: DUR_W];
  assign w_dur_ms = CNT_W'(int'(w_dur) * DUR_UNIT);
  assign w_live   = (live_note != '0);
  assign w_cnt_tc = (r_cnt == CNT_W'(1));

  // The prescaler runs in every PLAY/GAP cycle, including the cycle that
  // enters PAUSE, so a pause only removes the cycles actually spent paused.
  assign w_pre_en  = (r_state == ST_PLAY) || (r_state == ST_GAP);
  assign w_pre_clr = (r_state == ST_LOAD);

  tick_prescaler #(.TICK_CYC(TICK_CYC)) u_tick (
    .i_clk    (sys_clk),
    .i_rst    (rst_n),
    .i_clr    (w_pre_clr),
    .i_en     (w_pre_en),
    .o_ms_tick(w_ms_tick)
  );

  always_ff @(posedge sys_clk or posedge rst_n) begin
    if (rst_n) begin
      r_state     <= ST_IDLE;
      r_ret       <= ST_PLAY;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_notes     <= '0;
      r_shift     <= '0;
      r_ent_notes <= '0;
      r_ent_oct   <= '0;
      r_ent_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ret   <= w_ret_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_notes <= w_notes_nxt;
      r_shift <= w_shift_nxt;
      if (r_state == ST_LOAD) begin
        r_ent_notes <= rom_data[NOTE_LSB +: NOTE_W];
        r_ent_oct   <= rom_data[OCT_LSB +: OCT_W];
        r_ent_last  <= rom_data[LAST_BIT];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ret_nxt   = r_ret;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_notes_nxt = r_notes;
    w_shift_nxt = r_shift;
    if (auto_stop && (r_state != ST_IDLE)) begin
      w_state_nxt = ST_IDLE;
      w_notes_nxt = live_note;
      w_shift_nxt = live_shift;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_notes_nxt = live_note;
          w_shift_nxt = live_shift;
          if (auto_req) begin
            w_state_nxt = ST_FETCH;
            w_addr_nxt  = '0;
            w_notes_nxt = '0;
          end
        end
        ST_FETCH: begin
          w_state_nxt = ST_LOAD;
          w_notes_nxt = '0;
        end
        ST_LOAD: begin
          if (w_dur == '0) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_PLAY;
            w_cnt_nxt   = w_dur_ms;
            w_notes_nxt = rom_data[NOTE_LSB +: NOTE_W];
            w_shift_nxt = rom_data[OCT_LSB +: OCT_W];
          end
        end
        ST_PLAY: begin
          // Note expiry beats a simultaneous key press; the pause then
          // lands in GAP on the following edge.
          if (w_ms_tick && w_cnt_tc) begin
            w_state_nxt = ST_GAP;
            w_cnt_nxt   = CNT_W'(GAP_MS);
            w_notes_nxt = '0;
          end else begin
            if (w_ms_tick) w_cnt_nxt = r_cnt - CNT_W'(1);
            if (w_live) begin
              w_state_nxt = ST_PAUSE;
              w_ret_nxt   = ST_PLAY;
              w_notes_nxt = live_note;
              w_shift_nxt = live_shift;
            end
          end
        end
        ST_GAP: begin
          if (w_ms_tick && w_cnt_tc) begin
            // Address wrap is treated as end of song.
            if (r_ent_last || (r_addr == '1)) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_FETCH;
              w_addr_nxt  = r_addr + ADDR_W'(1);
            end
          end else begin
            if (w_ms_tick) w_cnt_nxt = r_cnt - CNT_W'(1);
            if (w_live) begin
              w_state_nxt = ST_PAUSE;
              w_ret_nxt   = ST_GAP;
              w_notes_nxt = live_note;
              w_shift_nxt = live_shift;
            end
          end
        end
        ST_PAUSE: begin
          if (w_live) begin
            w_notes_nxt = live_note;
            w_shift_nxt = live_shift;
          end else begin
            w_state_nxt = r_ret;
            if (r_ret == ST_PLAY) begin
              w_notes_nxt = r_ent_notes;
              w_shift_nxt = r_ent_oct;
            end else begin
              w_notes_nxt = '0;
            end
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          w_notes_nxt = live_note;
          w_shift_nxt = live_shift;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign rom_addr  = r_addr;
  assign notes     = r_notes;
  assign shift     = r_shift;
  assign busy      = (r_state != ST_IDLE);
  assign song_done = (r_state == ST_DONE);

endmodule

// File: tb/tb_play_scheduler.sv
// Self-checking bench for play_scheduler: directed song scenarios with
// literal timing expectations plus randomized traffic against a
// cycle-counting behavioural model.
module tb_play_scheduler;

  localparam int TICK_CYC = 4;
  localparam int DUR_UNIT = 1;
  localparam int GAP_MS   = 2;
  localparam int ADDR_W   = 3;

  localparam int M_IDLE = 0, M_FETCH = 1, M_LOAD = 2, M_PLAY = 3,
                 M_GAP = 4, M_PAUSE = 5, M_DONE = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        live_note = '0;
  logic [1:0]        live_shift = '0;
  logic              auto_req = 1'b0;
  logic              auto_stop = 1'b0;
  logic [ADDR_W-1:0] rom_addr;
  logic [17:0]       rom_q;
  logic [7:0]        notes;
  logic [1:0]        shift;
  logic              busy;
  logic              song_done;

  logic [17:0] rom_mem [0:7];

  int  n_chk = 0;
  int  n_err = 0;
  bit  chk_en = 1'b0;

  always #5 clk = ~clk;

  play_scheduler #(
    .TICK_CYC(TICK_CYC), .DUR_UNIT(DUR_UNIT), .GAP_MS(GAP_MS), .ADDR_W(ADDR_W)
  ) dut (
    .sys_clk   (clk),
    .rst_n     (rst),
    .live_note (live_note),
    .live_shift(live_shift),
    .auto_req  (auto_req),
    .auto_stop (auto_stop),
    .rom_addr  (rom_addr),
    .rom_data  (rom_q),
    .notes     (notes),
    .shift     (shift),
    .busy      (busy),
    .song_done (song_done)
  );

  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  function automatic logic [17:0] ent(input logic [7:0] n, input logic [1:0] o,
                                      input int d, input logic last);
    return {last, 7'(d), o, n};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (cycle-count timing) ----------------
  int          m_ph, m_ret, m_rem;
  logic [2:0]  m_addr;
  logic [7:0]  m_notes;
  logic [1:0]  m_shift;
  logic [17:0] m_ent;

  always @(posedge clk or posedge rst) begin : model
    int ph, rem, ret;
    logic [2:0] addr;
    logic [7:0] nt;
    logic [1:0] sh;
    logic [17:0] e;
    logic live;
    if (rst) begin
      m_ph <= M_IDLE; m_ret <= M_PLAY; m_rem <= 0; m_addr <= '0;
      m_notes <= '0; m_shift <= '0; m_ent <= '0;
    end else begin
      ph = m_ph; rem = m_rem; ret = m_ret; addr = m_addr;
      nt = m_notes; sh = m_shift; e = m_ent;
      live = (live_note != 0);
      if (auto_stop && ph != M_IDLE) begin
        ph = M_IDLE; nt = live_note; sh = live_shift;
      end else begin
        case (ph)
          M_IDLE: begin
            nt = live_note; sh = live_shift;
            if (auto_req) begin ph = M_FETCH; addr = 0; nt = 0; end
          end
          M_FETCH: begin ph = M_LOAD; nt = 0; end
          M_LOAD: begin
            e = rom_mem[addr];
            if (e[16:10] == 0) ph = M_DONE;
            else begin
              ph = M_PLAY;
              rem = int'(e[16:10]) * DUR_UNIT * TICK_CYC;
              nt = e[7:0]; sh = e[9:8];
            end
          end
          M_PLAY, M_GAP: begin
            rem = rem - 1;
            if (rem == 0) begin
              if (ph == M_PLAY) begin
                ph = M_GAP; rem = GAP_MS * TICK_CYC; nt = 0;
              end else if (e[17] || addr == 3'd7) begin
                ph = M_DONE;
              end else begin
                ph = M_FETCH; addr = addr + 3'd1;
              end
            end else if (live) begin
              ret = ph; ph = M_PAUSE; nt = live_note; sh = live_shift;
            end
          end
          M_PAUSE: begin
            if (live) begin
              nt = live_note; sh = live_shift;
            end else begin
              ph = ret;
              if (ret == M_PLAY) begin nt = e[7:0]; sh = e[9:8]; end
              else nt = 0;
            end
          end
          default: begin ph = M_IDLE; nt = live_note; sh = live_shift; end
        endcase
      end
      m_ph <= ph; m_rem <= rem; m_ret <= ret; m_addr <= addr;
      m_notes <= nt; m_shift <= sh; m_ent <= e;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("notes", int'(notes), int'(m_notes));
      chk("shift", int'(shift), int'(m_shift));
      chk("busy", int'(busy), (m_ph != M_IDLE) ? 1 : 0);
      chk("song_done", int'(song_done), (m_ph == M_DONE) ? 1 : 0);
      chk("rom_addr", int'(rom_addr), int'(m_addr));
    end
  end

  // ---------------- trace helpers for literal checks ----------------
  logic [7:0] tr_notes[$];
  bit         tr_done[$];
  bit         tr_busy[$];

  task automatic clear_trace();
    tr_notes.delete(); tr_done.delete(); tr_busy.delete();
  endtask

  task automatic sample();
    tr_notes.push_back(notes);
    tr_done.push_back(song_done);
    tr_busy.push_back(busy);
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      @(negedge clk);
    end
  endtask

  function automatic int run_len(input int start, input logic [7:0] v);
    int l = 0;
    while (start + l < tr_notes.size() && tr_notes[start + l] == v) l++;
    return l;
  endfunction

  function automatic int first_done();
    for (int i = 0; i < tr_done.size(); i++) if (tr_done[i]) return i;
    return -1;
  endfunction

  function automatic int count_done();
    int c = 0;
    for (int i = 0; i < tr_done.size(); i++) if (tr_done[i]) c++;
    return c;
  endfunction

  task automatic pulse_req();
    auto_req = 1'b1;
    @(negedge clk);
    auto_req = 1'b0;
  endtask

  initial begin
    int idx, l, nz;
    for (int i = 0; i < 8; i++) rom_mem[i] = '0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst notes", int'(notes), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst addr", int'(rom_addr), 0);
    chk("rst done", int'(song_done), 0);
    rst = 1'b0;
    @(negedge clk);

    // live passthrough
    live_note = 8'h04; live_shift = 2'd2;
    @(negedge clk);
    chk("live notes", int'(notes), 8'h04);
    chk("live shift", int'(shift), 2);
    chk("live busy", int'(busy), 0);
    live_note = '0; live_shift = '0;
    @(negedge clk);

    // two-note song
    rom_mem[0] = ent(8'h01, 2'd1, 2, 1'b0);
    rom_mem[1] = ent(8'h10, 2'd2, 1, 1'b1);
    pulse_req();
    clear_trace();
    capture(40);
    idx = 0;
    l = run_len(idx, 8'h00); chk("song lead zeros", l, 2);  idx += l;
    l = run_len(idx, 8'h01); chk("song note0 len", l, 8);   idx += l;
    l = run_len(idx, 8'h00); chk("song gap len", l, 10);    idx += l;
    l = run_len(idx, 8'h10); chk("song note1 len", l, 4);   idx += l;
    l = run_len(idx, 8'h00); chk("song tail zeros", l, 16);
    chk("song done idx", first_done(), 32);
    chk("song done cnt", count_done(), 1);
    chk("song busy after", int'(tr_busy[33]), 0);

    // pause during first note
    pulse_req();
    clear_trace();
    for (int k = 0; k < 30; k++) begin
      sample();
      if (k >= 4 && k <= 8) begin live_note = 8'h80; live_shift = 2'd3; end
      else begin live_note = '0; live_shift = '0; end
      @(negedge clk);
    end
    idx = 0;
    l = run_len(idx, 8'h00); chk("pause lead zeros", l, 2); idx += l;
    l = run_len(idx, 8'h01); chk("pause pre len", l, 3);    idx += l;
    l = run_len(idx, 8'h80); chk("pause live len", l, 5);   idx += l;
    l = run_len(idx, 8'h01); chk("pause rest len", l, 5);
    repeat (15) @(negedge clk);

    // zero-duration first entry
    rom_mem[0] = ent(8'h55, 2'd1, 0, 1'b0);
    pulse_req();
    clear_trace();
    capture(8);
    chk("dur0 done idx", first_done(), 2);
    nz = 0;
    for (int i = 0; i < tr_notes.size(); i++) if (tr_notes[i] != 0) nz++;
    chk("dur0 no notes", nz, 0);

    // stop during GAP with simultaneous request
    rom_mem[0] = ent(8'h01, 2'd1, 2, 1'b0);
    pulse_req();
    clear_trace();
    for (int k = 0; k < 25; k++) begin
      sample();
      auto_stop = (k == 12); auto_req = (k == 12);
      @(negedge clk);
    end
    chk("stop busy before", int'(tr_busy[12]), 1);
    chk("stop busy after", int'(tr_busy[13]), 0);
    chk("stop no done", count_done(), 0);

    // eight non-last entries: end on address wrap
    for (int i = 0; i < 8; i++) rom_mem[i] = ent(8'(1 << i), 2'(i), 1, 1'b0);
    pulse_req();
    clear_trace();
    capture(120);
    chk("wrap done idx", first_done(), 112);
    chk("wrap done cnt", count_done(), 1);
    chk("wrap addr", int'(rom_addr), 7);

    // reset in the middle of a note
    rom_mem[0] = ent(8'h01, 2'd1, 2, 1'b1);
    pulse_req();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst notes", int'(notes), 0);
    chk("midrst shift", int'(shift), 0);
    chk("midrst busy", int'(busy), 0);
    chk("midrst addr", int'(rom_addr), 0);
    rst = 1'b0;
    @(negedge clk);

    // randomized traffic
    for (int r = 0; r < 4; r++) begin
      auto_stop = 1'b1;
      @(negedge clk);
      auto_stop = 1'b0;
      for (int i = 0; i < 8; i++)
        rom_mem[i] = ent(8'($urandom_range(1, 255)), 2'($urandom),
                         ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3),
                         ($urandom_range(0, 3) == 0));
      @(negedge clk);
      for (int c = 0; c < 600; c++) begin
        auto_req  = ($urandom_range(0, 24) == 0);
        auto_stop = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 15) == 0)
          live_note = (live_note != 0) ? 8'h00 : 8'($urandom_range(1, 255));
        live_shift = 2'($urandom);
        @(negedge clk);
      end
      auto_req = 1'b0; auto_stop = 1'b0; live_note = '0;
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
